order_gateway: RTL
==================

Name: order_gateway

Overview:
- Downstream stage of the trading decision core; consumes its registered trade_trigger / trade_price pair.
- Converts each new trade decision (rising edge of trade_trigger) into a sequence-numbered order.
- Enforces a per-window rate limit and buffers orders in a small FIFO toward the exchange-link packetizer.
- Presents orders on a valid/ready interface.

Parameters:
- PRICE_W, 64, width of trade_price / ord_price.
- SEQ_W, 16, width of order sequence number.
- FIFO_DEPTH, 4, order FIFO entries; power of 2, >=2.
- WINDOW_CYCLES, 1000, rate-limit window length in clk cycles; >=2.
- MAX_ORDERS, 8, max accepted orders per window; >=1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- trade_trigger  in  1  trade decision level from upstream core.
- trade_price  in  PRICE_W  price accompanying trade_trigger.
- enable  in  1  gateway enable; 0 discards new events without counting drops.
- ord_valid  out  1  FIFO head holds an order.
- ord_ready  in  1  downstream accepts head this cycle.
- ord_price  out  PRICE_W  head order price.
- ord_seq  out  SEQ_W  head order sequence number.
- drop_cnt  out  16  orders dropped (rate limit or FIFO full), saturating.
- throttled  out  1  window budget exhausted.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async assert, sync deassert use): trig_d=0, all FIFO pointers/count=0, next_seq=0, win_cnt=0, win_orders=0, drop_cnt=0. Outputs: ord_valid=0, ord_price=0, ord_seq=0, throttled=0, fifo_level=0. Reset mid-operation discards all FIFO contents; next sequence restarts at 0.
- Edge detect: trig_d <= trade_trigger every cycle. event = trade_trigger & ~trig_d. A held-high trigger yields exactly one event.
- pop = ord_valid & ord_ready.
- Event with enable=0: ignored; no drop, no seq advance.
- Event with enable=1 is accepted iff win_orders < MAX_ORDERS AND (count < FIFO_DEPTH OR pop).
  - A push into a full FIFO while popping the same cycle is accepted.
  - An accepted event writes {trade_price sampled that cycle, next_seq}, then next_seq++ (wraps 2^SEQ_W-1 -> 0), win_orders++.
- Rejected event (rate limit or full): drop_cnt++, saturating at 16'hFFFF. next_seq and win_orders are unchanged.
- Window: win_cnt counts 0..WINDOW_CYCLES-1 and wraps.
  - On the wrap cycle, win_orders <= (accepted this cycle ? 1 : 0).
  - An accept decision on the wrap cycle uses the pre-wrap win_orders.
- throttled: registered; equals (win_orders == MAX_ORDERS) as of the next cycle's state.
- FIFO: head outputs are driven from storage (no extra register).
  - ord_valid = (count != 0); fifo_level = count.
  - Latency: event sampled at edge N -> ord_valid=1 after edge N, visible in cycle N+1.
  - While ord_valid=1 and ord_ready=0, ord_price and ord_seq hold stable.
  - When the FIFO is empty, ord_price/ord_seq show the last-written or reset contents; values are don't-care while ord_valid=0.
- Simultaneous push+pop: count unchanged; ordering strictly FIFO.
- Arithmetic: pointers are log2(FIFO_DEPTH) bits with natural wrap; count is one bit wider.

Test Plan:
- Reset, then trade_trigger 0->1 held 5 cycles with price 0x1234, ord_ready=1 -> exactly one order: ord_valid 1 cycle after edge, ord_price=0x1234, ord_seq=0; drop_cnt=0.
- Pulse trigger 6 times (1 high, 1 low), prices 1..6, ord_ready=0 -> seq 0..3 buffered, fifo_level=4, drop_cnt=2. Then ord_ready=1 -> prices 1,2,3,4 drained in order, fifo_level returns to 0.
- MAX_ORDERS=8, ord_ready=1: 10 events inside one window -> 8 orders (seq 0..7), drop_cnt=2, throttled=1. After the window wrap, throttled=0 and the next event gives seq 8.
- FIFO full, ord_ready=1, and an event on the same cycle -> push accepted, fifo_level stays 4, no drop.
- Event on the window-wrap cycle while win_orders=MAX_ORDERS -> dropped. Event on the next cycle -> accepted, win_orders=1.
- Assert rst_n=0 mid-drain with fifo_level=3 -> ord_valid=0 and fifo_level=0 immediately (async). After release, the next event yields ord_seq=0. Also with enable=0, events give no orders and no drop_cnt increment.

Source files
------------

// File: rtl/order_gateway.sv
// Purpose: turns rising edges of trade_trigger into sequence-numbered orders, rate-limited per window, buffered in a FIFO.
// Latency: an event sampled at clock edge N is presented on ord_valid/ord_price/ord_seq in cycle N+1.
// Backpressure: ord_ready low holds the head stable; events arriving at a full FIFO (with no pop) or over budget are dropped and counted.
module order_gateway #(
    parameter int PRICE_W       = 64,
    parameter int SEQ_W         = 16,
    parameter int FIFO_DEPTH    = 4,
    parameter int WINDOW_CYCLES = 1000,
    parameter int MAX_ORDERS    = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            trade_trigger,
    input  logic [PRICE_W-1:0]              trade_price,
    input  logic                            enable,
    output logic                            ord_valid,
    input  logic                            ord_ready,
    output logic [PRICE_W-1:0]              ord_price,
    output logic [SEQ_W-1:0]                ord_seq,
    output logic [15:0]                     drop_cnt,
    output logic                            throttled,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LVL_W = AW + 1;
    localparam int WC_W  = $clog2(WINDOW_CYCLES);
    localparam int WO_W  = $clog2(MAX_ORDERS + 1);
    localparam int ENT_W = PRICE_W + SEQ_W;

    localparam logic [LVL_W-1:0] DEPTH_L  = LVL_W'(FIFO_DEPTH);
    localparam logic [WC_W-1:0]  WIN_LAST = WC_W'(WINDOW_CYCLES - 1);
    localparam logic [WO_W-1:0]  MAX_O    = WO_W'(MAX_ORDERS);

    logic                 trig_d;
    logic [SEQ_W-1:0]     next_seq;
    logic [WC_W-1:0]      win_cnt;
    logic [WO_W-1:0]      win_orders;
    logic [WO_W-1:0]      win_orders_nxt;
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [LVL_W-1:0]     count;
    logic [ENT_W-1:0]     mem [FIFO_DEPTH];

    logic                 trig_evt;
    logic                 pop;
    logic                 accept;
    logic                 drop;
    logic                 win_wrap;

    // Head is read straight out of storage, so a held head never changes while ready is low.
    assign {ord_price, ord_seq} = mem[rd_ptr];
    assign ord_valid  = (count != '0);
    assign fifo_level = count;

    // A pop frees a slot in the same cycle, so a full FIFO being drained still takes the new order.
    always_comb begin
        trig_evt = trade_trigger & ~trig_d;
        pop      = ord_valid & ord_ready;
        win_wrap = (win_cnt == WIN_LAST);
        accept   = trig_evt & enable & (win_orders < MAX_O) & ((count < DEPTH_L) | pop);
        drop     = trig_evt & enable & ~accept;
        if (win_wrap) begin
            // an order accepted on the wrap cycle is charged to the new window
            win_orders_nxt = accept ? WO_W'(1) : '0;
        end else if (accept) begin
            win_orders_nxt = win_orders + 1'b1;
        end else begin
            win_orders_nxt = win_orders;
        end
    end

    // Edge detector, sequence numbering, rate-limit window and drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_d     <= 1'b0;
            next_seq   <= '0;
            win_cnt    <= '0;
            win_orders <= '0;
            throttled  <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            trig_d     <= trade_trigger;
            win_cnt    <= win_wrap ? '0 : win_cnt + 1'b1;
            win_orders <= win_orders_nxt;
            throttled  <= (win_orders_nxt == MAX_O);
            if (accept) begin
                next_seq <= next_seq + 1'b1;
            end
            if (drop && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    // Order FIFO: storage, pointers with natural wrap, and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (accept) begin
                mem[wr_ptr] <= {trade_price, next_seq};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
